// File: rtl/vga_pkg.sv
// vga_pkg: framebuffer geometry, scan fetch spacing and arbiter state shared by the VGA blocks
package vga_pkg;
  localparam int FB_ADDR_W    = 13;
  localparam int FB_DATA_W    = 24;
  localparam int SCAN_MIN_GAP = 8;
  typedef enum logic [1:0] {IDLE, SCAN_RD, HOST_WR, HOST_RD} fb_state_t;
endpackage

// File: rtl/fb_read_tag_pipe.sv
// fb_read_tag_pipe: follows each granted operation through the RAM latency and steers ram_rdata to its requester
module fb_read_tag_pipe import vga_pkg::*; #(
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  fb_state_t         tag,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid
);
  fb_state_t s1, s2;
  logic [DATA_W-1:0] scan_q, host_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= IDLE;
      s2     <= IDLE;
      scan_q <= '0;
      host_q <= '0;
    end else begin
      s1 <= tag;
      s2 <= s1;
      if (scan_valid) scan_q <= ram_rdata;
      if (host_rvalid) host_q <= ram_rdata;
    end
  end
  // the returning word is forwarded in its arrival cycle and held afterwards
  assign scan_valid  = s2 == SCAN_RD;
  assign host_rvalid = s2 == HOST_RD;
  assign scan_data   = scan_valid ? ram_rdata : scan_q;
  assign host_rdata  = host_rvalid ? ram_rdata : host_q;
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer sharing with absolute scanout priority over a host port
module vga_fb_arbiter #(
  parameter int ADDR_W       = vga_pkg::FB_ADDR_W,
  parameter int DATA_W       = vga_pkg::FB_DATA_W,
  parameter int SCAN_MIN_GAP = vga_pkg::SCAN_MIN_GAP
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              overrun,
  input  logic              overrun_clr
);
  import vga_pkg::*;
  fb_state_t state, next_state;
  logic [3:0] gap;
  logic host_g, viol;
  always_comb begin
    host_g     = host_valid && !scan_req;
    next_state = scan_req ? SCAN_RD : host_g ? (host_we ? HOST_WR : HOST_RD) : IDLE;
    viol       = scan_req && gap != 4'd0;
  end
  assign host_ready = host_g;
  assign ram_en     = state != IDLE;
  assign ram_we     = state == HOST_WR;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ram_addr  <= '0;
      ram_wdata <= '0;
      gap       <= '0;
      overrun   <= 1'b0;
    end else begin
      state <= next_state;
      if (scan_req) ram_addr <= scan_addr;
      else if (host_g) ram_addr <= host_addr;
      if (host_g && host_we) ram_wdata <= host_wdata;
      if (scan_req) gap <= 4'(SCAN_MIN_GAP - 1);
      else if (gap != 4'd0) gap <= gap - 4'd1;
      overrun <= viol || (overrun && !overrun_clr);
    end
  end
  fb_read_tag_pipe #(.DATA_W(DATA_W)) u_tag (
    .clock      (clock),
    .reset_n    (reset_n),
    .tag        (next_state),
    .ram_rdata  (ram_rdata),
    .scan_data  (scan_data),
    .scan_valid (scan_valid),
    .host_rdata (host_rdata),
    .host_rvalid(host_rvalid)
  );
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed and randomized traffic against a memory/scoreboard reference of the arbiter
module tb_vga_fb_arbiter;
  import vga_pkg::*;
  localparam int AW  = FB_ADDR_W;
  localparam int DW  = FB_DATA_W;
  localparam int GAP = SCAN_MIN_GAP;
  logic clock = 0, reset_n = 0;
  logic scan_req = 0, host_valid = 0, host_we = 0, overrun_clr = 0;
  logic [AW-1:0] scan_addr = '0, host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic [DW-1:0] scan_data, host_rdata, ram_wdata, ram_rdata;
  logic scan_valid, host_ready, host_rvalid, ram_en, ram_we, overrun;
  logic [AW-1:0] ram_addr;
  always #5 clock = ~clock;
  vga_fb_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_data(scan_data), .scan_valid(scan_valid),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {11'h2A5, a};
  endfunction
  // framebuffer BRAM: unwritten words read back as the address pattern
  logic [DW-1:0] ram [0:(1<<AW)-1];
  bit wr_mask [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) begin
        ram[ram_addr]     <= ram_wdata;
        wr_mask[ram_addr] <= 1'b1;
      end
      ram_rdata <= wr_mask[ram_addr] ? ram[ram_addr] : pat(ram_addr);
    end
  end
  typedef struct {int due; bit scan; logic [DW-1:0] d;} rsp_t;
  rsp_t q[$];
  logic [DW-1:0] mref [0:(1<<AW)-1];
  int cyc = 0, last_scan = -1000, checks = 0, errors = 0;
  bit ov_e, p_en, p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wd, sd_e, hd_e;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step(input bit sr, input logic [AW-1:0] sa, input bit hv, input bit hwe,
                      input logic [AW-1:0] ha, input logic [DW-1:0] hwd, input bit clr, output bit acc);
    bit sv_e, hv_e;
    @(negedge clock);
    scan_req = sr; scan_addr = sa; host_valid = hv; host_we = hwe;
    host_addr = ha; host_wdata = hwd; overrun_clr = clr;
    #1;
    sv_e = 0; hv_e = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].scan) begin sv_e = 1; sd_e = q[0].d; end
      else begin hv_e = 1; hd_e = q[0].d; end
      q.delete(0);
    end
    chk("scan_valid", 32'(scan_valid), 32'(sv_e));
    chk("scan_data", 32'(scan_data), 32'(sd_e));
    chk("host_rvalid", 32'(host_rvalid), 32'(hv_e));
    chk("host_rdata", 32'(host_rdata), 32'(hd_e));
    chk("overrun", 32'(overrun), 32'(ov_e));
    chk("ram_en", 32'(ram_en), 32'(p_en));
    chk("ram_we", 32'(ram_we), 32'(p_we));
    if (p_en) chk("ram_addr", 32'(ram_addr), 32'(p_addr));
    if (p_we) chk("ram_wdata", 32'(ram_wdata), 32'(p_wd));
    acc = hv && !sr;
    chk("host_ready", 32'(host_ready), 32'(acc));
    p_en = sr || acc;
    p_we = acc && hwe;
    if (sr) begin
      p_addr = sa;
      q.push_back('{due: cyc + 2, scan: 1'b1, d: mref[sa]});
      if (cyc - last_scan < GAP) ov_e = 1;
      else if (clr) ov_e = 0;
      last_scan = cyc;
    end else begin
      if (clr) ov_e = 0;
      if (acc) begin
        p_addr = ha;
        if (hwe) begin mref[ha] = hwd; p_wd = hwd; end
        else q.push_back('{due: cyc + 2, scan: 1'b0, d: mref[ha]});
      end
    end
    cyc++;
  endtask
  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, '0, 0, a);
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset_n = 0; scan_req = 0; host_valid = 0; host_we = 0; overrun_clr = 0;
    #1;
    chk("rst_scan_data", 32'(scan_data), 0);
    chk("rst_scan_valid", 32'(scan_valid), 0);
    chk("rst_host_ready", 32'(host_ready), 0);
    chk("rst_host_rdata", 32'(host_rdata), 0);
    chk("rst_host_rvalid", 32'(host_rvalid), 0);
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_overrun", 32'(overrun), 0);
    repeat (2) @(negedge clock);
    reset_n = 1;
    q.delete();
    sd_e = '0; hd_e = '0; ov_e = 0; p_en = 0; p_we = 0; last_scan = -1000;
  endtask
  initial begin
    bit a, pend, pwe;
    int k;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    for (int i = 0; i < (1 << AW); i++) mref[i] = pat(AW'(i));
    do_reset();
    idle(2);
    step(0, '0, 1, 0, AW'('h40), '0, 0, a);
    do_reset();
    idle(5);
    step(0, '0, 1, 1, AW'('h10), 24'hABCDEF, 0, a);
    step(0, '0, 1, 0, AW'('h10), '0, 0, a);
    idle(2);
    chk("wr_then_rd", 32'(host_rdata), 32'h00ABCDEF);
    idle(8);
    step(1, AW'('h20), 1, 0, AW'('h30), '0, 0, a);
    step(0, '0, 1, 0, AW'('h30), '0, 0, a);
    idle(3);
    chk("collide_host_rdata", 32'(host_rdata), 32'(pat(AW'('h30))));
    idle(6);
    for (int i = 0; i < 80; i++) begin
      step(1, AW'(i), 0, 0, '0, '0, 0, a);
      idle(GAP - 1);
    end
    chk("stream_no_overrun", 32'(overrun), 0);
    step(1, AW'(5), 0, 0, '0, '0, 0, a);
    idle(2);
    step(1, AW'(6), 0, 0, '0, '0, 0, a);
    idle(1);
    chk("spacing_overrun_set", 32'(overrun), 1);
    step(0, '0, 0, 0, '0, '0, 1, a);
    idle(1);
    chk("spacing_overrun_clr", 32'(overrun), 0);
    idle(GAP);
    k = 0;
    pd = DW'($urandom);
    for (int n = 0; n < 300 && k < 100; n++) begin
      step(cyc - last_scan >= GAP, AW'($urandom), 1, 1, AW'('h1000 + k), pd, 0, a);
      if (a) begin k++; pd = DW'($urandom); end
    end
    chk("sat_accepted", 32'(k), 100);
    idle(GAP);
    for (int i = 0; i < 100; i++) step(0, '0, 1, 0, AW'('h1000 + i), '0, 0, a);
    idle(3);
    pend = 0; pwe = 0; pa = '0; pd = '0;
    for (int n = 0; n < 600; n++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1; pwe = $urandom_range(0, 1) == 1; pa = AW'($urandom_range(0, 31)); pd = DW'($urandom);
      end
      step((cyc - last_scan >= GAP && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0,
           AW'($urandom_range(0, 31)), pend, pwe, pa, pd, $urandom_range(0, 19) == 0, a);
      if (a) pend = 0;
    end
    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
